// File: rtl/ucie_ctl_sb_tx_serializer_pkg.sv
// Shared sideband definitions: FSM encoding, phase/gap sizes, header parity bit positions.
// Holds the header parity helper used when UCIE_SB_TX_PARITY_EN is defined.
package ucie_ctl_sb_pkg;

  typedef enum logic [1:0] {
    SB_IDLE = 2'd0,
    SB_HDR  = 2'd1,
    SB_DATA = 2'd2,
    SB_GAP  = 2'd3
  } sb_tx_state_e;

  localparam int SB_QW_BITS    = 64;
  localparam int SB_GAP_BITS   = 32;
  localparam int SB_HDR_CP_BIT = 62;
  localparam int SB_HDR_DP_BIT = 63;

  // A counter is never narrower than one bit, even when a phase is a single beat.
  function automatic int sb_cnt_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  // CP covers the header bits below the parity pair; DP covers the payload, or 0 with no payload.
  function automatic logic [SB_QW_BITS-1:0] sb_hdr_with_parity(
    input logic [SB_QW_BITS-1:0] hdr,
    input logic [SB_QW_BITS-1:0] data,
    input logic                  has_data
  );
    logic [SB_QW_BITS-1:0] h;
    h = hdr;
    h[SB_HDR_CP_BIT] = ^hdr[SB_HDR_CP_BIT-1:0];
    h[SB_HDR_DP_BIT] = has_data ? ^data : 1'b0;
    return h;
  endfunction

endpackage

// File: rtl/ucie_ctl_sb_tx_serializer_if.sv
// Packet-side and lane-side signals of the sideband TX serializer.
// Packet handshake: a packet transfers on a clock edge where i_pkt_valid and o_pkt_ready are both 1;
// the offering side holds its fields stable until then, and o_pkt_ready never depends on i_pkt_valid.
interface ucie_ctl_sb_tx_serializer_if #(
  parameter int N = 16
) ();

  logic                          i_pkt_valid;
  logic                          o_pkt_ready;
  logic [63:0]                   i_pkt_header;
  logic [63:0]                   i_pkt_data;
  logic                          i_pkt_has_data;
  logic                          i_tx_en;
  logic [N-1:0]                  o_tx_data;
  logic                          o_tx_valid;
  logic                          o_busy;
  logic                          o_pkt_done;
  ucie_ctl_sb_pkg::sb_tx_state_e o_state;
  logic [5:0]                    o_beat_cnt;

  modport slave (
    input  i_pkt_valid, i_pkt_header, i_pkt_data, i_pkt_has_data, i_tx_en,
    output o_pkt_ready, o_tx_data, o_tx_valid, o_busy, o_pkt_done, o_state, o_beat_cnt
  );

  modport master (
    output i_pkt_valid, i_pkt_header, i_pkt_data, i_pkt_has_data, i_tx_en,
    input  o_pkt_ready, o_tx_data, o_tx_valid, o_busy, o_pkt_done, o_state, o_beat_cnt
  );

endinterface

// File: rtl/ucie_ctl_sb_tx_serializer_beat_cnt.sv
// Enable-gated up-counter with a programmable terminal value, terminal-count flag and sync clear.
// Wraps to zero on an enabled cycle at terminal count, so it never overflows.
module ucie_ctl_sb_tx_beat_cnt #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic [W-1:0] i_term,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);

  logic [W-1:0] cnt_q;

  assign o_tc  = (cnt_q == i_term);
  assign o_cnt = cnt_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      cnt_q <= '0;
    end else if (i_clr) begin
      cnt_q <= '0;
    end else if (i_en) begin
      cnt_q <= o_tc ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/ucie_ctl_sb_tx_serializer.sv
// Sideband TX serializer: one header (+ optional payload) out as N-bit beats LSB first, then an idle gap.
// Define UCIE_SB_TX_PARITY_EN to overwrite header bits 63:62 with DP/CP at accept.
module ucie_ctl_sb_tx_serializer
  import ucie_ctl_sb_pkg::*;
#(
  parameter int N = 16
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  ucie_ctl_sb_tx_serializer_if.slave sb
);

  localparam int BEATS_PER_QW = SB_QW_BITS / N;
  localparam int GAP_BEATS    = SB_GAP_BITS / N;
  localparam int CNT_W        = sb_cnt_w(BEATS_PER_QW);
  localparam logic [CNT_W-1:0] QW_TERM  = CNT_W'(BEATS_PER_QW - 1);
  localparam logic [CNT_W-1:0] GAP_TERM = CNT_W'(GAP_BEATS - 1);

  sb_tx_state_e              state_q, state_n;
  logic [2*SB_QW_BITS-1:0]   shift_q;
  logic                      has_data_q;
  logic                      done_q;
  logic                      accept, cnt_en, shift_en, done_n;
  logic                      beat_tc;
  logic [CNT_W-1:0]          beat_cnt, beat_term;
  logic [SB_QW_BITS-1:0]     hdr_in, data_in;

`ifdef UCIE_SB_TX_PARITY_EN
  assign hdr_in = sb_hdr_with_parity(sb.i_pkt_header, sb.i_pkt_data, sb.i_pkt_has_data);
`else
  assign hdr_in = sb.i_pkt_header;
`endif

  // A header-only packet loads a zero payload, so the shifter drains to zero for the gap.
  assign data_in   = sb.i_pkt_has_data ? sb.i_pkt_data : '0;
  assign beat_term = (state_q == SB_GAP) ? GAP_TERM : QW_TERM;

  ucie_ctl_sb_tx_beat_cnt #(
    .W (CNT_W)
  ) u_beat_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (cnt_en),
    .i_clr   (accept),
    .i_term  (beat_term),
    .o_cnt   (beat_cnt),
    .o_tc    (beat_tc)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= SB_IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    accept   = 1'b0;
    cnt_en   = 1'b0;
    shift_en = 1'b0;
    done_n   = 1'b0;
    case (state_q)
      SB_IDLE: begin
        if (sb.i_pkt_valid) begin
          accept  = 1'b1;
          state_n = SB_HDR;
        end
      end
      SB_HDR: begin
        if (sb.i_tx_en) begin
          cnt_en   = 1'b1;
          shift_en = 1'b1;
          if (beat_tc) begin
            state_n = has_data_q ? SB_DATA : SB_GAP;
          end
        end
      end
      SB_DATA: begin
        if (sb.i_tx_en) begin
          cnt_en   = 1'b1;
          shift_en = 1'b1;
          if (beat_tc) begin
            state_n = SB_GAP;
          end
        end
      end
      SB_GAP: begin
        if (sb.i_tx_en) begin
          cnt_en = 1'b1;
          if (beat_tc) begin
            state_n = SB_IDLE;
            done_n  = 1'b1;
          end
        end
      end
      default: state_n = SB_IDLE;
    endcase
  end

  // Current beat always sits in the low N bits of the shifter, which is a register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      shift_q    <= '0;
      has_data_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= done_n;
      if (accept) begin
        shift_q    <= {data_in, hdr_in};
        has_data_q <= sb.i_pkt_has_data;
      end else if (shift_en) begin
        shift_q <= shift_q >> N;
      end
    end
  end

  assign sb.o_pkt_ready = (state_q == SB_IDLE);
  assign sb.o_busy      = (state_q != SB_IDLE);
  assign sb.o_tx_valid  = (state_q == SB_HDR) || (state_q == SB_DATA);
  assign sb.o_tx_data   = shift_q[N-1:0];
  assign sb.o_pkt_done  = done_q;
  assign sb.o_state     = state_q;
  assign sb.o_beat_cnt  = 6'(beat_cnt);

  a_ready_not_busy: assert property (@(posedge i_clk) disable iff (!i_reset)
    sb.o_pkt_ready == !sb.o_busy);
  a_done_in_idle: assert property (@(posedge i_clk) disable iff (!i_reset)
    sb.o_pkt_done |-> (state_q == SB_IDLE));
  a_gap_quiet: assert property (@(posedge i_clk) disable iff (!i_reset)
    (state_q == SB_GAP) |-> (shift_q[N-1:0] == '0));

endmodule

// File: tb/tb_ucie_ctl_sb_tx_serializer.sv
// Bench for the sideband TX serializer: directed table at N=16 plus a randomized sweep at N=8,1,4,32
// checked against a beat-stream model of the packet format.
module tb_ucie_ctl_sb_tx_serializer;
  import ucie_ctl_sb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  logic sw_rst_n;

  int checks   = 0;
  int failures = 0;

  // ---------------- main DUT, N=16 ----------------
  ucie_ctl_sb_tx_serializer_if #(.N(16)) mif();
  ucie_ctl_sb_tx_serializer #(.N(16)) u_dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .sb      (mif)
  );

  // ---------------- sweep DUTs ----------------
  logic        sw_valid [4];
  logic        sw_hd    [4];
  logic        sw_en    [4];
  logic [63:0] sw_hdr   [4];
  logic [63:0] sw_dat   [4];
  logic [31:0] sw_txd   [4];
  logic        sw_txv   [4];
  logic        sw_rdy   [4];
  logic        sw_busy  [4];
  logic        sw_done  [4];

  function automatic int sw_n(input int i);
    return (i == 0) ? 8 : (i == 1) ? 1 : (i == 2) ? 4 : 32;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_sw
    localparam int NN = (g == 0) ? 8 : (g == 1) ? 1 : (g == 2) ? 4 : 32;
    ucie_ctl_sb_tx_serializer_if #(.N(NN)) sif();
    ucie_ctl_sb_tx_serializer #(.N(NN)) u_sw (
      .i_clk   (clk),
      .i_reset (sw_rst_n),
      .sb      (sif)
    );
    assign sif.i_pkt_valid    = sw_valid[g];
    assign sif.i_pkt_header   = sw_hdr[g];
    assign sif.i_pkt_data     = sw_dat[g];
    assign sif.i_pkt_has_data = sw_hd[g];
    assign sif.i_tx_en        = sw_en[g];
    assign sw_txd[g]  = 32'(sif.o_tx_data);
    assign sw_txv[g]  = sif.o_tx_valid;
    assign sw_rdy[g]  = sif.o_pkt_ready;
    assign sw_busy[g] = sif.o_busy;
    assign sw_done[g] = sif.o_pkt_done;
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        v;
    logic [31:0] d;
  } ent_t;

  ent_t mq [4][$];
  logic mdone [4];

  function automatic logic [63:0] ref_hdr(input logic [63:0] h, input logic [63:0] d, input logic hd);
    logic [63:0] r;
    r = h;
`ifdef UCIE_SB_TX_PARITY_EN
    begin
      logic cp;
      logic dp;
      cp = 1'b0;
      dp = 1'b0;
      for (int i = 0; i < 62; i++) cp = cp ^ h[i];
      if (hd) for (int i = 0; i < 64; i++) dp = dp ^ d[i];
      r[62] = cp;
      r[63] = dp;
    end
`else
    if (hd && (d === 64'hx)) r = h;
`endif
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks (main DUT) ----------------
  task automatic idle_inputs();
    mif.i_pkt_valid    = 1'b0;
    mif.i_pkt_header   = '0;
    mif.i_pkt_data     = '0;
    mif.i_pkt_has_data = 1'b0;
    mif.i_tx_en        = 1'b1;
  endtask

  // Offer one packet at a negedge with lane always enabled and walk every beat.
  // stall_at: beat index where i_tx_en drops for 3 cycles; abort_at: beat index where reset hits.
  task automatic xfer(input logic [63:0] hdr, input logic [63:0] dat, input logic hd,
                      input logic [63:0] eh, input logic [63:0] ed,
                      input int stall_at, input int abort_at);
    int nb;
    logic [15:0] eb;
    chk("ready_before_accept", 64'(mif.o_pkt_ready), 64'd1);
    mif.i_pkt_valid    = 1'b1;
    mif.i_pkt_header   = hdr;
    mif.i_pkt_data     = dat;
    mif.i_pkt_has_data = hd;
    mif.i_tx_en        = 1'b1;
    @(negedge clk);
    mif.i_pkt_valid    = 1'b0;
    mif.i_pkt_header   = ~hdr;
    mif.i_pkt_data     = ~dat;
    mif.i_pkt_has_data = ~hd;
    nb = hd ? 8 : 4;
    for (int k = 0; k < nb; k++) begin
      eb = (k < 4) ? eh[16*k +: 16] : ed[16*(k-4) +: 16];
      chk("tx_beat", {47'd0, mif.o_tx_valid, mif.o_tx_data}, {47'd0, 1'b1, eb});
      chk("ready_low_in_packet", 64'(mif.o_pkt_ready), 64'd0);
      if (k == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", {59'd0, mif.o_tx_valid, (mif.o_tx_data != 16'd0), mif.o_busy,
                              mif.o_pkt_done, mif.o_pkt_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 4; j++) begin
          @(negedge clk);
          chk("abort_no_done", {62'd0, mif.o_pkt_done, mif.o_busy}, 64'd0);
        end
        return;
      end
      if (k == stall_at) begin
        mif.i_tx_en = 1'b0;
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          chk("stall_hold", {47'd0, mif.o_tx_valid, mif.o_tx_data}, {47'd0, 1'b1, eb});
        end
        mif.i_tx_en = 1'b1;
      end
      @(negedge clk);
    end
    for (int k = 0; k < 2; k++) begin
      chk("gap_beat", {45'd0, mif.o_tx_valid, mif.o_tx_data, mif.o_busy, mif.o_pkt_done},
          {45'd0, 1'b0, 16'd0, 1'b1, 1'b0});
      @(negedge clk);
    end
    chk("done_pulse", {61'd0, mif.o_pkt_done, mif.o_pkt_ready, mif.o_busy}, {61'd0, 3'b110});
    @(negedge clk);
    chk("done_cleared", 64'(mif.o_pkt_done), 64'd0);
  endtask

  // ---------------- directed table ----------------
  typedef struct packed {
    logic [63:0] hdr;
    logic [63:0] dat;
    logic        hd;
    logic [63:0] eh_plain;
    logic [63:0] eh_par;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [63:0] eh;
    ent_t e;
    logic [63:0] h;
    logic [63:0] msk;
    int n;

    rst_n    = 1'b0;
    sw_rst_n = 1'b0;
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      sw_valid[i] = 1'b0; sw_hd[i] = 1'b0; sw_en[i] = 1'b0;
      sw_hdr[i] = '0; sw_dat[i] = '0; mdone[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("reset_ready",    64'(mif.o_pkt_ready), 64'd1);
    chk("reset_tx_valid", 64'(mif.o_tx_valid),  64'd0);
    chk("reset_tx_data",  64'(mif.o_tx_data),   64'd0);
    chk("reset_busy",     64'(mif.o_busy),      64'd0);
    chk("reset_done",     64'(mif.o_pkt_done),  64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    vecs[0] = '{64'h0123_4567_89AB_CDEF, 64'h0, 1'b0,
                64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF};
    vecs[1] = '{64'h0123_4567_89AB_CDEF, 64'hFFFF_0000_AAAA_5555, 1'b1,
                64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF};
    vecs[2] = '{64'h1, 64'h3, 1'b1, 64'h1, 64'h4000_0000_0000_0001};
    vecs[3] = '{64'h1, 64'h7, 1'b1, 64'h1, 64'hC000_0000_0000_0001};
    vecs[4] = '{64'h8000_0000_0000_0000, 64'hDEAD_BEEF_0000_0001, 1'b0,
                64'h8000_0000_0000_0000, 64'h0};
    vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1,
                64'hFFFF_FFFF_FFFF_FFFF, 64'h3FFF_FFFF_FFFF_FFFF};

    for (int v = 0; v < 6; v++) begin
`ifdef UCIE_SB_TX_PARITY_EN
      eh = vecs[v].eh_par;
`else
      eh = vecs[v].eh_plain;
`endif
      xfer(vecs[v].hdr, vecs[v].dat, vecs[v].hd, eh, vecs[v].dat, -1, -1);
    end

    // multi-cycle corners: lane stall mid-header, reset mid-payload, recovery packet
    xfer(64'h0123_4567_89AB_CDEF, 64'h0, 1'b0, 64'h0123_4567_89AB_CDEF, 64'h0, 2, -1);
    xfer(64'h0123_4567_89AB_CDEF, 64'hFFFF_0000_AAAA_5555, 1'b1,
         64'h0123_4567_89AB_CDEF, 64'hFFFF_0000_AAAA_5555, -1, 5);
    xfer(64'h0123_4567_89AB_CDEF, 64'h0, 1'b0, 64'h0123_4567_89AB_CDEF, 64'h0, -1, -1);

    // randomized sweep over beat widths against the beat-stream model
    sw_rst_n = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        n = sw_n(i);
        e = (mq[i].size() != 0) ? mq[i][0] : '0;
        chk($sformatf("sweep_n%0d_cyc%0d", n, cyc),
            64'({sw_txv[i], sw_txd[i], sw_rdy[i], sw_busy[i], sw_done[i]}),
            64'({e.v, e.d, (mq[i].size() == 0), (mq[i].size() != 0), mdone[i]}));
        sw_valid[i] = (cyc < 60) ? 1'b1 : ($urandom_range(0, 4) != 0);
        sw_en[i]    = (cyc < 60) ? 1'b1 : ($urandom_range(0, 3) != 0);
        sw_hd[i]    = (cyc < 60) ? 1'b0 : 1'($urandom_range(0, 1));
        sw_hdr[i]   = {$urandom, $urandom};
        sw_dat[i]   = {$urandom, $urandom};
        msk = (64'd1 << n) - 64'd1;
        if (mq[i].size() == 0 && sw_valid[i]) begin
          h = ref_hdr(sw_hdr[i], sw_dat[i], sw_hd[i]);
          for (int k = 0; k < 64 / n; k++) mq[i].push_back('{1'b1, 32'((h >> (k * n)) & msk)});
          if (sw_hd[i])
            for (int k = 0; k < 64 / n; k++)
              mq[i].push_back('{1'b1, 32'((sw_dat[i] >> (k * n)) & msk)});
          for (int k = 0; k < 32 / n; k++) mq[i].push_back('{1'b0, 32'd0});
          mdone[i] = 1'b0;
        end else if (mq[i].size() != 0 && sw_en[i]) begin
          void'(mq[i].pop_front());
          mdone[i] = (mq[i].size() == 0);
        end else begin
          mdone[i] = 1'b0;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
